// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out framer.
// Captures a DATA_W-bit word on a valid/ready handshake and emits it one bit
// per clock, MSB or LSB first, optionally followed by an even-parity bit.
// A new word can be taken on the last bit of a frame, so frames run
// back-to-back with no idle gap.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active high
//   din        - parallel word to serialize
//   din_valid  - din holds a valid word
//   din_ready  - word can be accepted this cycle (decoded from state only)
//   dout       - serial bit
//   dout_valid - dout carries a frame bit
//   dout_last  - dout is the final bit of the frame
//   busy       - a frame is in progress
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int PAR_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              busy
);

  localparam int FRAME_LEN = DATA_W + ((PAR_EN != 0) ? 1 : 0);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  // Two-hot-free encoding: 2'b00 and 2'b11 are illegal and fall back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [FRAME_LEN-1:0]   fr, fr_d;      // frame in transmit order, next bit at MSB
  logic [FRAME_LEN-1:0]   frame_in;
  logic                   dv, dv_d;
  logic                   dl, dl_d;
  logic                   accept;
  logic                   at_last;

  // Reorder the incoming word so the first transmitted bit lands in the top
  // position; parity (when enabled) takes the bottom slot.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < DATA_W; k++)
      frame_in[FRAME_LEN-1-k] = (MSB_FIRST != 0) ? din[DATA_W-1-k] : din[k];
    if (PAR_EN != 0)
      frame_in[0] = ^din;
  end

  assign at_last   = (state == SHIFT) && (cnt == LAST);
  assign din_ready = !rst && ((state == IDLE) || at_last);
  assign accept    = din_valid && din_ready;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fr_d    = fr;
    dv_d    = 1'b0;
    dl_d    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          fr_d    = frame_in;
          dv_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          if (accept) begin
            cnt_d = '0;
            fr_d  = frame_in;
            dv_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            fr_d    = '0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
          fr_d  = fr << 1;
          dv_d  = 1'b1;
          dl_d  = (cnt_d == LAST);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fr_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fr    <= '0;
      dv    <= 1'b0;
      dl    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      fr    <= fr_d;
      dv    <= dv_d;
      dl    <= dl_d;
    end
  end

  assign dout       = fr[FRAME_LEN-1];
  assign dout_valid = dv;
  assign dout_last  = dl;
  assign busy       = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first no parity, LSB-first
// with parity) checked every cycle against a queue-of-pending-bits model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din1 = '0, din2 = '0;
  logic       vld1 = 1'b0, vld2 = 1'b0;
  logic       rdy1, dout1, dv1, dl1, busy1;
  logic       rdy2, dout2, dv2, dl2, busy2;

  int n_vec = 0;
  int n_err = 0;
  int acc1n = 0, acc2n = 0;
  bit q1[$];
  bit q2[$];
  logic [3:0] win = '0;
  bit seen1101 = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1), .PAR_EN(0)) u_dut (
    .clk(clk), .rst(rst), .din(din1), .din_valid(vld1), .din_ready(rdy1),
    .dout(dout1), .dout_valid(dv1), .dout_last(dl1), .busy(busy1)
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(0), .PAR_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(vld2), .din_ready(rdy2),
    .dout(dout2), .dout_valid(dv2), .dout_last(dl2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mready(input int sz);
    return !rst && (sz <= 1);
  endfunction

  task automatic push1(input logic [7:0] w);
    for (int k = 0; k < 8; k++) q1.push_back(w[7-k]);
  endtask

  task automatic push2(input logic [7:0] w);
    for (int k = 0; k < 8; k++) q2.push_back(w[k]);
    q2.push_back(^w);
  endtask

  task automatic check_all();
    chk("d1.dout",  dout1, q1.size() > 0 ? q1[0] : 1'b0);
    chk("d1.valid", dv1,   q1.size() > 0);
    chk("d1.last",  dl1,   q1.size() == 1);
    chk("d1.busy",  busy1, q1.size() > 0);
    chk("d1.ready", rdy1,  mready(q1.size()));
    chk("d2.dout",  dout2, q2.size() > 0 ? q2[0] : 1'b0);
    chk("d2.valid", dv2,   q2.size() > 0);
    chk("d2.last",  dl2,   q2.size() == 1);
    chk("d2.busy",  busy2, q2.size() > 0);
    chk("d2.ready", rdy2,  mready(q2.size()));
  endtask

  // One clock: decide acceptance from model ready before the edge, advance the
  // model at the edge, then compare just after it.
  task automatic tick();
    bit a1, a2;
    a1 = vld1 && mready(q1.size());
    a2 = vld2 && mready(q2.size());
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (q1.size() > 0) void'(q1.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (a1) begin push1(din1); acc1n++; end
      if (a2) begin push2(din2); acc2n++; end
    end
    #1;
    check_all();
    if (dv1) begin
      win = {win[2:0], dout1};
      if (win == 4'b1101) seen1101 = 1'b1;
    end
  endtask

  initial begin
    // Reset asserted between edges: outputs must clear without a clock.
    #1 rst = 1'b1;
    #1 check_all();
    tick();
    tick();
    rst = 1'b0;

    // Idle with din_valid low and din wiggling.
    for (int i = 0; i < 20; i++) begin
      din1 = 8'($urandom);
      din2 = 8'($urandom);
      tick();
    end

    // Single frames: 0xB6 MSB-first, 0x07 LSB-first with parity.
    win = '0;
    seen1101 = 1'b0;
    din1 = 8'hB6; vld1 = 1'b1;
    din2 = 8'h07; vld2 = 1'b1;
    tick();
    vld1 = 1'b0; vld2 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      din1 = 8'($urandom);
      din2 = 8'($urandom);
      tick();
    end
    chk("det1101", seen1101, 1'b1);

    // Back-to-back: valid held high, second word taken on the last bit.
    acc1n = 0; acc2n = 0;
    for (int i = 0; i < 22; i++) begin
      vld1 = (acc1n < 2);
      din1 = (acc1n == 0) ? 8'hB6 : 8'h0F;
      vld2 = (acc2n < 2);
      din2 = (acc2n == 0) ? 8'h07 : 8'hA5;
      tick();
    end
    vld1 = 1'b0; vld2 = 1'b0;

    // Backpressure: valid high with din changing every cycle.
    for (int i = 0; i < 40; i++) begin
      vld1 = 1'b1; din1 = 8'($urandom);
      vld2 = 1'b1; din2 = 8'($urandom);
      tick();
    end
    vld1 = 1'b0; vld2 = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Reset mid-frame after 3 bits of 0xB6.
    din1 = 8'hB6; vld1 = 1'b1;
    din2 = 8'hB6; vld2 = 1'b1;
    tick();
    vld1 = 1'b0; vld2 = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    q1.delete();
    q2.delete();
    #1 check_all();
    tick();
    rst = 1'b0;
    tick();
    din1 = 8'hFF; vld1 = 1'b1;
    din2 = 8'hFF; vld2 = 1'b1;
    tick();
    vld1 = 1'b0; vld2 = 1'b0;
    for (int i = 0; i < 11; i++) tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      vld1 = 1'($urandom_range(0, 1)); din1 = 8'($urandom);
      vld2 = 1'($urandom_range(0, 1)); din2 = 8'($urandom);
      tick();
    end
    vld1 = 1'b0; vld2 = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_W, default 8: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit bit DATA_W-1 first; 0 = transmit bit 0 first.
REQ-003 Parameter PAR_EN, default 0: 1 = append one even-parity bit after the data bits.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port din, input, DATA_W: parallel word to serialize.
REQ-007 Port din_valid, input, 1: din holds a valid word.
REQ-008 Port din_ready, output, 1: block can accept a word this cycle (combinational from state only; never from din_valid).
REQ-009 Port dout, output, 1: serial bit, feeds the downstream sequence detector's din.
REQ-010 Port dout_valid, output, 1: dout carries a frame bit this cycle.
REQ-011 Port dout_last, output, 1: dout is the final bit of the current frame.
REQ-012 Port busy, output, 1: a frame is in progress.

Function
REQ-013 FRAME_LEN SHALL be DATA_W+PAR_EN bits.
REQ-014 States: IDLE and SHIFT; a bit counter runs 0..FRAME_LEN-1; a shift register holds the captured word.
REQ-015 Handshake: a word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1.
- din SHALL be captured into the shift register at that edge.
- Later changes on din SHALL NOT affect the frame.
REQ-016 din_ready SHALL be 1 in IDLE, and 1 in SHIFT only when the counter equals FRAME_LEN-1; it SHALL be 0 at all other times.
REQ-017 IDLE -> SHIFT on acceptance; counter set to 0.
REQ-018 Latency: the first frame bit SHALL appear on dout with dout_valid=1 in the cycle after acceptance.
REQ-019 In SHIFT:
- dout_valid SHALL be 1.
- One bit is emitted per cycle in MSB_FIRST order.
- The counter increments every cycle.
REQ-020 When PAR_EN=1, bit FRAME_LEN-1 SHALL be the XOR of all DATA_W captured bits (even parity).
REQ-021 dout_last SHALL be 1 only while the counter equals FRAME_LEN-1 in SHIFT.
REQ-022 On the last bit:
- With acceptance: stay in SHIFT, reload the shift register, reset the counter to 0. The next cycle carries bit 0 of the new frame with no idle gap.
- Without acceptance: go to IDLE.
REQ-023 In IDLE: dout=0, dout_valid=0, dout_last=0, busy=0; din_valid is ignored whenever din_ready=0.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 dout, dout_valid and dout_last SHALL be driven from registers (no combinational path from din).
REQ-026 Illegal or unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 While rst=1, the block SHALL immediately (without waiting for clk) force:
- state=IDLE, counter=0, shift register=0
- dout=0, dout_valid=0, dout_last=0, busy=0, din_ready=0
REQ-028 rst asserted mid-frame SHALL abort the frame. The remaining bits are discarded and never emitted.
REQ-029 After rst deasserts, din_ready SHALL be 1 at the first rising edge, and normal operation SHALL begin from IDLE.

Verification
REQ-030 Basic frame (DATA_W=8, MSB_FIRST=1): accept din=0xB6 -> dout = 1,0,1,1,0,1,1,0 on 8 consecutive cycles, starting 1 cycle after acceptance. dout_valid=1 for exactly 8 cycles; dout_last=1 on the 8th bit only. The downstream detector fed by dout SHALL report Y=1 for the 1101 pattern contained in this frame.
REQ-031 Back-to-back: hold din_valid=1 and present 0xB6 then 0x0F (the second word accepted on the last-bit cycle) -> 16 contiguous valid bits 10110110 00001111, no gap, din_ready high only on cycles 0 (IDLE) and 8.
REQ-032 LSB-first plus parity (MSB_FIRST=0, PAR_EN=1): accept din=0x07 -> dout = 1,1,1,0,0,0,0,0,1 (9 bits; parity=1). dout_last on the 9th bit.
REQ-033 Backpressure: din_valid=1 with changing din during SHIFT -> no word is accepted. The frame in flight is unchanged; the next word is captured only when din_ready=1.
REQ-034 Reset mid-frame: assert rst after 3 bits of 0xB6 -> outputs go to 0 immediately with no clk edge. After release, a new word 0xFF serializes as eight 1s with nothing from 0xB6 emitted.
REQ-035 Idle behaviour: din_valid=0 for 20 cycles after reset -> dout_valid=0, dout=0, busy=0, din_ready=1 throughout.
